cla_add_arbiter: RTL and testbench
==================================

Name: cla_add_arbiter

Overview:
- Shares one combinational cla_24bit adder instance among NUM_REQ requesters.
- Round-robin arbitration selects a requester and registers its operand pair. The adder result is captured one cycle later and held on a valid/ready response port, tagged with the requester index.
- Sits between the operand-producing clients and the single adder. It sequences every use of the adder; no client drives the adder directly.

Parameters:
- WIDTH, 24, operand width passed to the cla_24bit instance.
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, requester index width, equal to clog2(NUM_REQ); 1 when NUM_REQ=2.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- o_req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit high.
- i_add1  input  NUM_REQ*WIDTH  operand 1 for each requester; requester k uses slice [k*WIDTH +: WIDTH].
- i_add2  input  NUM_REQ*WIDTH  operand 2, sliced the same way.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response consumer ready.
- o_rsp_result  output  WIDTH+1  sum; the carry-out is in the MSB.
- o_rsp_id  output  ID_W  index of the requester that owns the response.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state=IDLE, rr_ptr=0.
  - Operand registers, o_rsp_result, o_rsp_id cleared to 0.
  - o_rsp_valid=0, o_req_ready=0, o_busy=0.
  - Any in-flight transaction is discarded; no response is ever produced for it.
- States: IDLE, ADD, RESP.
- IDLE:
  - o_req_ready is combinational: a one-hot grant to the first valid requester, searching upward from rr_ptr with wrap-around. It is all-zero if no request is valid.
  - On the edge where a grant occurs:
    - Latch that requester's i_add1/i_add2 slices and its index.
    - rr_ptr <= (granted index + 1) mod NUM_REQ.
    - Go to ADD.
  - With no valid request: stay in IDLE; rr_ptr is unchanged.
- ADD:
  - o_req_ready=0.
  - The adder evaluates the registered operands with carry-in 0.
  - On the edge, capture the WIDTH+1 result into o_rsp_result and the index into o_rsp_id, set o_rsp_valid=1, go to RESP.
- RESP:
  - o_req_ready=0. o_rsp_valid, o_rsp_result and o_rsp_id are held stable until i_rsp_ready=1.
  - On the handshake edge: o_rsp_valid <= 0, go to IDLE.
  - o_rsp_result and o_rsp_id keep their last value after the handshake.
- Latency and throughput:
  - Accept at edge N; o_rsp_valid high after edge N+1.
  - The earliest next accept is the edge after the response handshake, so the best case is one transaction every 3 cycles.
- Arithmetic:
  - Unsigned, no truncation: o_rsp_result = i_add1 + i_add2 as a WIDTH+1 value.
  - Example: all-ones + 1 = 2^WIDTH, i.e. MSB=1 with all lower bits 0.
- Requester contract:
  - A requester holds i_req_valid and its operands stable until it sees its o_req_ready bit.
  - A request that drops valid before being granted is simply never serviced.
- Simultaneous events:
  - Several requests valid: only the round-robin winner is granted; the others wait and are not dropped.
  - A request that rises while the state is ADD or RESP waits until IDLE.
  - Fairness: each continuously-valid requester is granted within NUM_REQ transactions.
- Response port: i_rsp_ready in IDLE or ADD has no effect.

Test Plan:
- Reset mid-RESP: assert i_rst_n=0 while o_rsp_valid=1 -> o_rsp_valid, o_busy and o_req_ready go to 0 immediately, without waiting for a clock edge. After release, a new req0 is granted (rr_ptr=0).
- Single request: req1 with 0x000005 + 0x00000A, i_rsp_ready=1 -> o_req_ready=4'b0010 for 1 cycle; o_rsp_valid high 2 edges later with o_rsp_result=0x000000F and o_rsp_id=1.
- Carry-out: 0xFFFFFF + 0x000001 -> o_rsp_result=25'h1000000. 0xFFFFFF + 0xFFFFFF -> 25'h1FFFFFE.
- Round-robin: all 4 requesters continuously valid with distinct operands -> grant order 0,1,2,3,0, and each o_rsp_id matches its own sum.
- Response backpressure: hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid, o_rsp_result and o_rsp_id remain stable, o_req_ready stays 0 and o_busy stays 1. Exactly one response is delivered when ready rises.
- Pointer wrap: grant req3 with req0 and req2 both valid -> the next grant is req0, not req2.

Source files
------------

// File: rtl/cla_add_arbiter.sv
// cla_add_arbiter: round-robin sharing of one carry-lookahead adder among NUM_REQ requesters,
// with a registered operand stage and a held valid/ready response tagged by requester index.
module cla_24bit #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  // Kogge-Stone prefix: after the loops g[i]/p[i] are group generate/propagate over bits [0..i]
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int d = 1; d < WIDTH; d = d * 2)
      for (int i = WIDTH - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    c = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) c[i+1] = g[i] | (p[i] & cin);
    sum = {c[WIDTH], a ^ b ^ c[WIDTH-1:0]};
  end
endmodule

module cla_add_arbiter #(
  parameter int WIDTH   = 24,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_add1,
  input  logic [NUM_REQ*WIDTH-1:0] i_add2,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [WIDTH:0]           o_rsp_result,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic                     o_busy
);
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   op_id;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   idx;
  logic              gnt_hit;
  logic [WIDTH-1:0]  op1;
  logic [WIDTH-1:0]  op2;
  logic [WIDTH:0]    sum;
  // Scan downward so the requester closest above rr_ptr is the last (winning) assignment
  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (i_req_valid[idx]) begin
        gnt_hit = 1'b1;
        gnt_id  = idx;
      end
    end
  end
  assign o_req_ready = (i_rst_n && state == IDLE && gnt_hit) ? NUM_REQ'(1) << gnt_id : '0;
  assign o_busy      = state != IDLE;
  cla_24bit #(.WIDTH(WIDTH)) u_add (
    .a   (op1),
    .b   (op2),
    .cin (1'b0),
    .sum (sum)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      op1          <= '0;
      op2          <= '0;
      op_id        <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_hit) begin
          op1    <= i_add1[gnt_id*WIDTH +: WIDTH];
          op2    <= i_add2[gnt_id*WIDTH +: WIDTH];
          op_id  <= gnt_id;
          rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state  <= ADD;
        end
        ADD: begin
          o_rsp_result <= sum;
          o_rsp_id     <= op_id;
          o_rsp_valid  <= 1'b1;
          state        <= RESP;
        end
        RESP: if (i_rsp_ready) begin
          o_rsp_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb_cla_add_arbiter: scoreboard bench; the driver predicts grants and sums, a monitor checks responses.
module tb_cla_add_arbiter;
  localparam int W = 24, N = 4, IW = 2;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] add1 = '0, add2 = '0;
  logic rsp_valid, rsp_ready = 1'b0, busy;
  logic [W:0] rsp_result;
  logic [IW-1:0] rsp_id;
  typedef struct { logic [W:0] sum; int id; int cyc; } exp_t;
  exp_t exp_q[$];
  int grant_log[$];
  int tests = 0, fails = 0, cyc = 0, ptr = 0, rsp_count = 0, mode = 0;
  logic rv[N], rearm[N];
  logic [W-1:0] op1[N], op2[N];
  int wait_c[N];
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int wr_exp[3] = '{3, 0, 2};
  int c0;

  cla_add_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_add1(add1), .i_add2(add2), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_id(rsp_id), .o_busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    int s;
    s = int'($urandom % 4);
    return s == 0 ? {W{1'b1}} : s == 1 ? {W{1'b0}} : W'($urandom);
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      add1[k*W +: W] = op1[k];
      add2[k*W +: W] = op2[k];
      req_valid[k] = rv[k];
    end
  endtask

  // One clock: predict/check a grant at the negedge, update requesters after the posedge
  task automatic cycle();
    int win;
    win = -1;
    @(negedge clk);
    if (req_ready != '0) begin
      for (int j = 0; j < N; j++) if (win < 0 && rv[(ptr + j) % N]) win = (ptr + j) % N;
      chk("grant_while_busy", exp_q.size(), 0);
      chk("grant_rr", req_ready, win < 0 ? 64'd0 : 64'd1 << win);
      if (win >= 0) begin
        exp_q.push_back('{sum: {1'b0, op1[win]} + {1'b0, op2[win]}, id: win, cyc: cyc});
        grant_log.push_back(win);
        ptr = (win + 1) % N;
      end
    end
    for (int k = 0; k < N; k++)
      if (rv[k] && k != win) begin
        wait_c[k]++;
        if (wait_c[k] > 60) begin
          tests++;
          fails++;
          $display("FAIL starve: req%0d waited %0d cycles, limit 60", k, wait_c[k]);
          rv[k] = 1'b0;
          wait_c[k] = 0;
        end
      end
    @(posedge clk);
    #1;
    if (win >= 0) begin
      wait_c[win] = 0;
      if (mode != 0) begin
        if ($urandom % 2 == 0) begin
          op1[win] = rnd_op();
          op2[win] = rnd_op();
        end else rv[win] = 1'b0;
      end else if (!rearm[win]) rv[win] = 1'b0;
    end
    if (mode != 0) begin
      for (int k = 0; k < N; k++)
        if (!rv[k] && $urandom % 4 == 0) begin
          rv[k] = 1'b1;
          op1[k] = rnd_op();
          op2[k] = rnd_op();
        end
      rsp_ready = ($urandom % 4) != 0;
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      rv[k] = 1'b0;
      rearm[k] = 1'b0;
    end
    drive();
  endtask

  // Monitor: checks held responses, first-valid contents/latency, and pops on handshake
  initial begin
    logic pv, pr;
    logic [W:0] pres;
    logic [IW-1:0] pid;
    exp_t e;
    pv = 1'b0; pr = 1'b0; pres = '0; pid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pv = 1'b0;
      else begin
        if (pv && !pr) begin
          chk("hold_valid", rsp_valid, 1);
          chk("hold_result", rsp_result, pres);
          chk("hold_id", rsp_id, pid);
        end
        if (rsp_valid) begin
          chk("resp_ready_low", req_ready, 0);
          chk("resp_busy", busy, 1);
          if (!pv) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL resp_unexpected: result %0h id %0d with nothing outstanding", rsp_result, rsp_id);
            end else begin
              e = exp_q[0];
              chk("resp_result", rsp_result, e.sum);
              chk("resp_id", rsp_id, e.id);
              chk("resp_latency", cyc - e.cyc, 2);
            end
          end
          if (rsp_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            rsp_count++;
          end
        end
        pv = rsp_valid; pr = rsp_ready; pres = rsp_result; pid = rsp_id;
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      rv[k] = 1'b1; rearm[k] = 1'b0; op1[k] = '0; op2[k] = '0; wait_c[k] = 0;
    end
    drive();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_id", rsp_id, 0);
    clear_reqs();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single request on req1
    rsp_ready = 1'b1;
    c0 = rsp_count;
    op1[1] = 24'h000005; op2[1] = 24'h00000A; rv[1] = 1'b1;
    drive();
    run(5);
    chk("single_count", rsp_count - c0, 1);

    // carry-out cases
    op1[2] = 24'hFFFFFF; op2[2] = 24'h000001; rv[2] = 1'b1;
    drive();
    run(5);
    op1[3] = 24'hFFFFFF; op2[3] = 24'hFFFFFF; rv[3] = 1'b1;
    drive();
    run(5);

    // round robin with all requesters continuously valid
    for (int k = 0; k < N; k++) begin
      op1[k] = W'(k * 24'h111111 + 7); op2[k] = W'(24'hABCDE0 + k); rv[k] = 1'b1; rearm[k] = 1'b1;
    end
    drive();
    grant_log.delete();
    for (int t = 0; t < 60 && grant_log.size() < 5; t++) cycle();
    clear_reqs();
    chk("rr_count", grant_log.size() >= 5, 1);
    for (int i = 0; i < 5; i++) chk("rr_order", i < grant_log.size() ? grant_log[i] : -1, rr_exp[i]);
    run(6);

    // response backpressure on req2
    rsp_ready = 1'b0;
    c0 = rsp_count;
    op1[2] = 24'h123456; op2[2] = 24'h654321; rv[2] = 1'b1;
    drive();
    run(8);
    chk("bp_none_yet", rsp_count - c0, 0);
    chk("bp_valid_held", rsp_valid, 1);
    rsp_ready = 1'b1;
    drive();
    run(4);
    chk("bp_one", rsp_count - c0, 1);

    // pointer wrap: req3 wins from ptr=3, then req0 ahead of req2
    grant_log.delete();
    op1[0] = 24'h000100; op2[0] = 24'h000200; rv[0] = 1'b1;
    op1[2] = 24'h000300; op2[2] = 24'h000400; rv[2] = 1'b1;
    op1[3] = 24'h800000; op2[3] = 24'h800000; rv[3] = 1'b1;
    drive();
    run(12);
    chk("wrap_count", grant_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("wrap_order", i < grant_log.size() ? grant_log[i] : -1, wr_exp[i]);

    // reset while a response is pending on req1
    rsp_ready = 1'b0;
    op1[1] = 24'h00ABCD; op2[1] = 24'h001111; rv[1] = 1'b1;
    drive();
    run(4);
    chk("pre_rst_valid", rsp_valid, 1);
    rst_n = 1'b0;
    clear_reqs();
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 0);
    exp_q.delete();
    ptr = 0;
    for (int k = 0; k < N; k++) wait_c[k] = 0;
    op1[0] = 24'h0F0F0F; op2[0] = 24'h00F0F0; rv[0] = 1'b1;
    op1[2] = 24'h333333; op2[2] = 24'h444444; rv[2] = 1'b1;
    drive();
    #1 chk("arst_req_gated", req_ready, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    grant_log.delete();
    run(8);
    chk("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    // randomized traffic with random backpressure
    mode = 1;
    run(600);
    mode = 0;
    rsp_ready = 1'b1;
    clear_reqs();
    run(10);
    chk("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
